// File: rtl/bcd_entry_pkg.sv
// Shared definitions for the BCD operand entry block: FSM encoding,
// button indices and decimal constants.
package bcd_entry_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    PRESENT = 2'd2
  } state_t;

  // Bit positions of the buttons inside the packed button vectors
  localparam int BTN_C    = 0;
  localparam int BTN_U    = 1;
  localparam int BTN_L    = 2;
  localparam int BTN_R    = 3;
  localparam int BTN_D    = 4;
  localparam int NUM_BTNS = 5;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int         BCD_MUL = 10;

  // Index width for a count of n items, never narrower than one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_operand_entry_button_debouncer.sv
// Counter-based debouncer for one raw push-button: 2-FF synchroniser,
// stable-state filter and a one-cycle pulse on every stable 0->1 edge.
module button_debouncer #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic stable_out,
  output logic press_pulse
);

  localparam int              CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // Synchronise, then accept the synced level once it has differed from the
  // stable state for DEB_CYCLES consecutive cycles; any agreement restarts it
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0     <= 1'b0;
      sync_p1     <= 1'b0;
      cnt         <= '0;
      stable_out  <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      sync_p0     <= btn_in;
      sync_p1     <= sync_p0;
      press_pulse <= 1'b0;
      if (sync_p1 == stable_out) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt         <= '0;
        stable_out  <= sync_p1;
        press_pulse <= sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_operand_entry.sv
// Multi-operand signed BCD entry from five push-buttons; commits the edited
// operand as two's-complement binary on a valid/ready handshake.
// Optional build macro BCD_ENTRY_AUTOREPEAT_EN adds auto-repeat on U and D.
module bcd_operand_entry
  import bcd_entry_pkg::*;
#(
  parameter int NUM_DIGITS    = 3,
  parameter int NUM_OPERANDS  = 2,
  parameter int VALUE_W       = 16,
  parameter int DEB_CYCLES    = 1000000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   bt_C,
  input  logic                                   bt_U,
  input  logic                                   bt_L,
  input  logic                                   bt_R,
  input  logic                                   bt_D,
  output logic [4*NUM_DIGITS-1:0]                digits_out,
  output logic                                   sign_out,
  output logic [$clog2(NUM_DIGITS+1)-1:0]        cursor_out,
  output logic [idx_w(NUM_OPERANDS)-1:0]         operand_sel_out,
  output logic                                   commit_valid,
  input  logic                                   commit_ready,
  output logic signed [VALUE_W-1:0]              commit_data,
  output logic [idx_w(NUM_OPERANDS)-1:0]         commit_idx
);

  localparam int CUR_W = $clog2(NUM_DIGITS + 1);
  localparam int SEL_W = idx_w(NUM_OPERANDS);
  localparam int IDX_W = idx_w(NUM_DIGITS);
  localparam logic [CUR_W-1:0] CUR_SIGN = CUR_W'(NUM_DIGITS);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_OPERANDS - 1);
  localparam logic [IDX_W-1:0] IDX_MSD  = IDX_W'(NUM_DIGITS - 1);

  // Sign applied to the converted magnitude; -0 naturally yields 0
  function automatic logic signed [VALUE_W-1:0] apply_sign(input logic neg,
                                                           input logic [VALUE_W-1:0] mag);
    logic signed [VALUE_W-1:0] s;
    s = signed'(mag);
    return neg ? -s : s;
  endfunction

  logic [NUM_BTNS-1:0] raw;
  logic [NUM_BTNS-1:0] stable;
  logic [NUM_BTNS-1:0] pulse;
  logic [NUM_BTNS-1:0] evt;
  logic [1:0]          rep_ud;
  logic                unused_stable;

  state_t state, state_nxt;

  logic [NUM_OPERANDS-1:0][4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_OPERANDS-1:0]                   signs_q;
  logic [CUR_W-1:0]                          cursor;
  logic [SEL_W-1:0]                          op_sel;
  logic [VALUE_W-1:0]                        acc;
  logic [VALUE_W-1:0]                        acc_nxt;
  logic [IDX_W-1:0]                          idx;
  logic [3:0]                                cur_digit;
  logic [3:0]                                conv_digit;
  logic [3:0]                                digit_inc;
  logic [3:0]                                digit_dec;

  assign raw           = {bt_D, bt_R, bt_L, bt_U, bt_C};
  assign unused_stable = &{1'b0, stable};

  for (genvar b = 0; b < NUM_BTNS; b++) begin : g_deb
    button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk        (clk),
      .reset      (reset),
      .btn_in     (raw[b]),
      .stable_out (stable[b]),
      .press_pulse(pulse[b])
    );
  end

`ifdef BCD_ENTRY_AUTOREPEAT_EN
  for (genvar g = 0; g < 2; g++) begin : g_rep
    localparam int BTN = (g == 0) ? BTN_U : BTN_D;
    logic [31:0] rep_cnt;
    logic        rep_armed;
    logic        rep_pulse;
    // Extra pulses while held in IDLE: first after REPEAT_DELAY, then every REPEAT_PERIOD
    always_ff @(posedge clk) begin
      if (reset || !stable[BTN] || state != IDLE) begin
        rep_cnt   <= '0;
        rep_armed <= 1'b0;
        rep_pulse <= 1'b0;
      end else begin
        rep_pulse <= 1'b0;
        if ((!rep_armed && rep_cnt == 32'(REPEAT_DELAY - 1)) ||
            ( rep_armed && rep_cnt == 32'(REPEAT_PERIOD - 1))) begin
          rep_pulse <= 1'b1;
          rep_armed <= 1'b1;
          rep_cnt   <= '0;
        end else begin
          rep_cnt <= rep_cnt + 32'd1;
        end
      end
    end
    assign rep_ud[g] = rep_pulse;
  end
`else
  localparam logic [31:0] unused_rep_cfg = 32'(REPEAT_DELAY + REPEAT_PERIOD);
  assign rep_ud = '0;
`endif

  assign evt = pulse | {rep_ud[1], 2'b00, rep_ud[0], 1'b0};

  // Digit under the cursor, digit being converted, and wrapped +/-1 values
  always_comb begin
    cur_digit  = '0;
    conv_digit = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (cursor == CUR_W'(d)) cur_digit  = digits_q[op_sel][d*4 +: 4];
      if (idx == IDX_W'(d))    conv_digit = digits_q[op_sel][d*4 +: 4];
    end
    digit_inc = (cur_digit == BCD_MAX) ? 4'd0 : cur_digit + 4'd1;
    digit_dec = (cur_digit == 4'd0) ? BCD_MAX : cur_digit - 4'd1;
    acc_nxt   = acc * VALUE_W'(BCD_MUL) + VALUE_W'(conv_digit);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state and handshake valid
  always_comb begin
    state_nxt    = state;
    commit_valid = 1'b0;
    case (state)
      IDLE:    if (evt[BTN_C]) state_nxt = CONVERT;
      CONVERT: if (idx == '0) state_nxt = PRESENT;
      PRESENT: begin
        commit_valid = 1'b1;
        if (commit_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Editing in IDLE (priority C > L > R > U > D), MSD-first conversion, commit
  always_ff @(posedge clk) begin
    if (reset) begin
      digits_q    <= '0;
      signs_q     <= '0;
      cursor      <= '0;
      op_sel      <= '0;
      acc         <= '0;
      idx         <= '0;
      commit_data <= '0;
      commit_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (evt[BTN_C]) begin
            acc <= '0;
            idx <= IDX_MSD;
          end else if (evt[BTN_L]) begin
            cursor <= (cursor == CUR_SIGN) ? '0 : cursor + 1'b1;
          end else if (evt[BTN_R]) begin
            cursor <= (cursor == '0) ? CUR_SIGN : cursor - 1'b1;
          end else if (evt[BTN_U] || evt[BTN_D]) begin
            if (cursor == CUR_SIGN) begin
              signs_q[op_sel] <= ~signs_q[op_sel];
            end else begin
              for (int d = 0; d < NUM_DIGITS; d++)
                if (cursor == CUR_W'(d))
                  digits_q[op_sel][d*4 +: 4] <= evt[BTN_U] ? digit_inc : digit_dec;
            end
          end
        end
        CONVERT: begin
          acc <= acc_nxt;
          idx <= idx - 1'b1;
          if (idx == '0) begin
            commit_data <= apply_sign(signs_q[op_sel], acc_nxt);
            commit_idx  <= op_sel;
          end
        end
        PRESENT: begin
          if (commit_ready) begin
            op_sel <= (op_sel == SEL_LAST) ? '0 : op_sel + 1'b1;
            cursor <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign digits_out      = digits_q[op_sel];
  assign sign_out        = signs_q[op_sel];
  assign cursor_out      = cursor;
  assign operand_sel_out = op_sel;

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Directed bench for bcd_operand_entry with DEB_CYCLES=4, 3 digits, 2 operands.
module tb_bcd_operand_entry;

  localparam int BC = 0, BU = 1, BL = 2, BR = 3, BD = 4;

  typedef struct {
    int          btn;
    logic [11:0] digits;
    logic        sign;
    logic [1:0]  cursor;
    logic        sel;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  raw = '0;
  logic        commit_ready = 1'b0;
  logic [11:0] digits_out;
  logic        sign_out;
  logic [1:0]  cursor_out;
  logic [0:0]  operand_sel_out;
  logic        commit_valid;
  logic [15:0] commit_data;
  logic [0:0]  commit_idx;

  int          compared = 0;
  int          mismatched = 0;
  int          xfers = 0;
  logic [15:0] last_data = '0;
  logic        last_idx = 1'b0;
  bit          hold_watch = 1'b0;
  int          hold_bad = 0;
  int          valid_seen = 0;
  vec_t        vq[$];

  always #5 clk = ~clk;

  bcd_operand_entry #(
    .NUM_DIGITS(3), .NUM_OPERANDS(2), .VALUE_W(16), .DEB_CYCLES(4),
    .REPEAT_DELAY(50), .REPEAT_PERIOD(20)
  ) dut (
    .clk(clk), .reset(reset),
    .bt_C(raw[BC]), .bt_U(raw[BU]), .bt_L(raw[BL]), .bt_R(raw[BR]), .bt_D(raw[BD]),
    .digits_out(digits_out), .sign_out(sign_out), .cursor_out(cursor_out),
    .operand_sel_out(operand_sel_out), .commit_valid(commit_valid),
    .commit_ready(commit_ready), .commit_data(commit_data), .commit_idx(commit_idx)
  );

  always @(posedge clk) begin
    if (!reset && commit_valid && commit_ready) begin
      xfers     <= xfers + 1;
      last_data <= commit_data;
      last_idx  <= commit_idx[0];
    end
  end

  always @(negedge clk) begin
    if (hold_watch && (!commit_valid || commit_data != 16'd1)) hold_bad <= hold_bad + 1;
    if (commit_valid) valid_seen <= valid_seen + 1;
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected summary before 20000 cycles");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [11:0] d, input logic s,
                             input logic [1:0] c, input logic sel);
    chk({tag, "_digits"}, 32'(digits_out), 32'(d));
    chk({tag, "_sign"}, 32'(sign_out), 32'(s));
    chk({tag, "_cursor"}, 32'(cursor_out), 32'(c));
    chk({tag, "_sel"}, 32'(operand_sel_out), 32'(sel));
  endtask

  task automatic press(input int b);
    raw[b] = 1'b1;
    repeat (10) @(negedge clk);
    raw[b] = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic add(input int b, input logic [11:0] d, input logic s,
                     input logic [1:0] c, input logic sel);
    vec_t v;
    v.btn = b; v.digits = d; v.sign = s; v.cursor = c; v.sel = sel;
    vq.push_back(v);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      press(vq[i].btn);
      check_state($sformatf("vec%0d", i), vq[i].digits, vq[i].sign, vq[i].cursor, vq[i].sel);
    end
  endtask

  task automatic wait_valid(output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 30) begin
      @(negedge clk);
      n++;
      seen = commit_valid;
    end
  endtask

  task automatic do_commit(input string tag, input logic [15:0] exp_data, input logic exp_idx);
    int n;
    bit seen;
    int x0;
    x0 = xfers;
    commit_ready = 1'b1;
    raw[BC] = 1'b1;
    wait_valid(n, seen);
    chk({tag, "_valid_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(n), 32'd10);
    chk({tag, "_data"}, 32'(commit_data), 32'(exp_data));
    chk({tag, "_idx"}, 32'(commit_idx), 32'(exp_idx));
    raw[BC] = 1'b0;
    repeat (12) @(negedge clk);
    chk({tag, "_xfers"}, 32'(xfers - x0), 32'd1);
    chk({tag, "_valid_low"}, 32'(commit_valid), 32'd0);
    chk({tag, "_xfer_data"}, 32'(last_data), 32'(exp_data));
  endtask

  initial begin
    int   n;
    bit   seen;
    int   x0;
    int   v0;

    // Edit sequence on operand 0: cursor walk, sign toggles, digits 9,0,7
    add(BL, 12'h001, 1'b0, 2'd1, 1'b0);
    add(BL, 12'h001, 1'b0, 2'd2, 1'b0);
    add(BL, 12'h001, 1'b0, 2'd3, 1'b0);
    add(BU, 12'h001, 1'b1, 2'd3, 1'b0);
    add(BL, 12'h001, 1'b1, 2'd0, 1'b0);
    add(BR, 12'h001, 1'b1, 2'd3, 1'b0);
    add(BD, 12'h001, 1'b0, 2'd3, 1'b0);
    add(BD, 12'h001, 1'b1, 2'd3, 1'b0);
    add(BR, 12'h001, 1'b1, 2'd2, 1'b0);
    add(BD, 12'h901, 1'b1, 2'd2, 1'b0);
    add(BR, 12'h901, 1'b1, 2'd1, 1'b0);
    add(BR, 12'h901, 1'b1, 2'd0, 1'b0);
    add(BD, 12'h900, 1'b1, 2'd0, 1'b0);
    add(BD, 12'h909, 1'b1, 2'd0, 1'b0);
    add(BD, 12'h908, 1'b1, 2'd0, 1'b0);
    add(BD, 12'h907, 1'b1, 2'd0, 1'b0);
    // Digit wrap without carry on operand 0
    add(BU, 12'h908, 1'b1, 2'd0, 1'b0);
    add(BU, 12'h909, 1'b1, 2'd0, 1'b0);
    add(BU, 12'h900, 1'b1, 2'd0, 1'b0);
    add(BD, 12'h909, 1'b1, 2'd0, 1'b0);
    // Operand 1 becomes -000
    add(BD, 12'h000, 1'b0, 2'd0, 1'b1);
    add(BL, 12'h000, 1'b0, 2'd1, 1'b1);
    add(BL, 12'h000, 1'b0, 2'd2, 1'b1);
    add(BL, 12'h000, 1'b0, 2'd3, 1'b1);
    add(BU, 12'h000, 1'b1, 2'd3, 1'b1);

    // Reset state
    repeat (3) @(negedge clk);
    check_state("reset", 12'h000, 1'b0, 2'd0, 1'b0);
    chk("reset_valid", 32'(commit_valid), 32'd0);
    chk("reset_data", 32'(commit_data), 32'd0);
    chk("reset_idx", 32'(commit_idx), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Bouncing U yields exactly one increment
    for (int i = 0; i < 10; i++) begin
      raw[BU] = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    chk("bounce_no_pulse", 32'(digits_out), 32'h000);
    raw[BU] = 1'b1;
    repeat (10) @(negedge clk);
    raw[BU] = 1'b0;
    repeat (10) @(negedge clk);
    check_state("bounce", 12'h001, 1'b0, 2'd0, 1'b0);

    run_vecs(0, 15);

    // Commit -907 from operand 0
    do_commit("c907", 16'hFC75, 1'b0);
    check_state("after_c907", 12'h000, 1'b0, 2'd0, 1'b1);

    // Backpressure on operand 1 holding value +1
    press(BU);
    check_state("op1_set", 12'h001, 1'b0, 2'd0, 1'b1);
    x0 = xfers;
    commit_ready = 1'b0;
    raw[BC] = 1'b1;
    wait_valid(n, seen);
    chk("bp_valid_seen", 32'(seen), 32'd1);
    chk("bp_data", 32'(commit_data), 32'd1);
    chk("bp_idx", 32'(commit_idx), 32'd1);
    raw[BC] = 1'b0;
    hold_watch = 1'b1;
    press(BU);
    press(BL);
    hold_watch = 1'b0;
    chk("bp_hold_stable", 32'(hold_bad), 32'd0);
    chk("bp_no_xfer", 32'(xfers - x0), 32'd0);
    check_state("bp_frozen", 12'h001, 1'b0, 2'd0, 1'b1);
    commit_ready = 1'b1;
    @(negedge clk);
    chk("bp_one_xfer", 32'(xfers - x0), 32'd1);
    chk("bp_xfer_data", 32'(last_data), 32'd1);
    chk("bp_xfer_idx", 32'(last_idx), 32'd1);
    @(negedge clk);
    chk("bp_valid_low", 32'(commit_valid), 32'd0);
    chk("bp_still_one", 32'(xfers - x0), 32'd1);
    check_state("revisit_op0", 12'h907, 1'b1, 2'd0, 1'b0);

    run_vecs(16, 19);
    do_commit("c909", 16'hFC73, 1'b0);
    run_vecs(20, 24);
    do_commit("cneg0", 16'h0000, 1'b1);
    check_state("after_cneg0", 12'h909, 1'b1, 2'd0, 1'b0);

    // Reset while converting aborts without a commit
    x0 = xfers;
    raw[BC] = 1'b1;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    raw[BC] = 1'b0;
    @(negedge clk);
    check_state("abort", 12'h000, 1'b0, 2'd0, 1'b0);
    chk("abort_valid", 32'(commit_valid), 32'd0);
    chk("abort_data", 32'(commit_data), 32'd0);
    chk("abort_idx", 32'(commit_idx), 32'd0);
    reset = 1'b0;
    v0 = valid_seen;
    repeat (20) @(negedge clk);
    chk("abort_no_valid", 32'(valid_seen - v0), 32'd0);
    chk("abort_no_xfer", 32'(xfers - x0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
